adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one W-bit adder datapath between N_REQ requesters with round-robin arbitration.
//  Each requester offers an (a, b) operand pair over a valid/ready handshake.
//  Results come back through a single registered response slot tagged with the requester id.
//  Sits between the ui_in-decoded operand sources and the uo_out result path of the tile.
// PARAMETERS
//  W      4  operand width in bits; result width is W+1 (carry in MSB)
//  N_REQ  4  number of requesters, 2..8; ID_W = clog2(N_REQ)
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  req_valid  in   N_REQ      per-requester operand valid
//  req_a      in   N_REQ*W    operand A, requester i at [i*W +: W]
//  req_b      in   N_REQ*W    operand B, same packing as req_a
//  req_ready  out  N_REQ      per-requester accept, one-hot or zero
//  rsp_valid  out  1          response slot holds a result
//  rsp_data   out  W+1        sum {carry, sum[W-1:0]}
//  rsp_id     out  ID_W       index of the requester that produced rsp_data
//  rsp_ready  in   1          consumer accepts the response
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=N_REQ-1, so requester 0 has top priority.
//    req_ready=0 while reset is asserted.
//  Slot FSM, two states:
//    EMPTY -> FULL on a grant.
//    FULL  -> EMPTY on rsp_ready with no grant.
//    FULL  -> FULL on rsp_ready with a grant (back-to-back).
//  can_accept = (state==EMPTY) | rsp_ready.
//    Combinational from rsp_ready; the path is fall-through by design.
//  Arbitration: search req_valid starting at rr_ptr+1 mod N_REQ; the first set bit wins.
//    req_ready[win] = can_accept; all other req_ready bits are 0.
//  Transfer: req_valid[i] & req_ready[i] at edge t.
//    At edge t: rsp_data <= a_i + b_i (zero-extended to W+1), rsp_id <= i, rr_ptr <= i.
//    rsp_valid=1 from cycle t+1. Latency is 1 cycle.
//    Throughput is 1 op/cycle while rsp_ready stays high.
//  rr_ptr updates only on a transfer. Idle cycles or stalls do not rotate priority.
//  Requesters hold valid, a and b stable until ready. Dropping valid before ready is legal;
//    the arbiter re-evaluates every cycle.
//  Backpressure: FULL & !rsp_ready -> all req_ready=0; rsp_data and rsp_id are held stable.
//  Wrap: W-bit overflow sets rsp_data[W]. Sums wrap modulo 2^(W+1), which never happens.
//  Reset mid-operation discards the slot contents. No response is emitted for the lost op.
// CONFIGURATION
//  ADDSHARE_SAT_EN defined:
//    rsp_data[W]=0.
//    On carry, rsp_data[W-1:0] saturates to all ones (W=4: 7+9 -> 5'h0F).
//  ADDSHARE_SAT_EN undefined: plain wrapping sum with carry in the MSB (7+9 -> 5'h10).
//  Latency, handshake and arbitration are identical in both builds.
// STRUCTURE
//  Package adder_share_pkg:
//    slot_state_e enum {EMPTY, FULL}.
//    function id_width(n) = clog2.
//    default W / N_REQ localparams.
//  Sub-module rr_arbiter:
//    parameter N.
//    inputs: req vector, ptr, enable.
//    outputs: one-hot grant, encoded grant index.
//    purely combinational.
//  The top holds the slot FSM, rr_ptr, the operand mux and the adder (one + operator).
// TESTING
//  1 Reset, then req_valid=0001, a0=3, b0=4, rsp_ready=1
//      -> req_ready=0001; next cycle rsp_valid=1, rsp_data=5'h07, rsp_id=0.
//  2 All four valid, a_i=i, b_i=1, rsp_ready=1 held
//      -> grants in order 0,1,2,3,0 on consecutive cycles; rsp_data=1,2,3,4,1.
//  3 Slot FULL, rsp_ready=0 for 3 cycles, req_valid=0110
//      -> req_ready=0000, rsp held stable;
//      -> raise rsp_ready: same-cycle grant to req 1 and back-to-back response.
//  4 a=4'hF, b=4'h1
//      -> rsp_data=5'h10 without ADDSHARE_SAT_EN; 5'h0F with it.
//  5 reset asserted while FULL with req_valid=1111
//      -> rsp_valid=0 immediately (async); after release the first grant goes to req 0.
//  6 Only req 2 valid for 5 cycles, then req 3 joins
//      -> req 3 is granted next; rr_ptr=2 was not disturbed by idle cycles.

Source files
------------

// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types, defaults and helpers for the adder-share arbiter
//
// Purpose : common definitions imported by adder_share_arbiter and rr_arbiter.
// Contents: slot_state_e  - response slot state (EMPTY/FULL)
//           DEFAULT_W     - default operand width
//           DEFAULT_N_REQ - default requester count
//           id_width()    - width of a requester index (clog2, minimum 1)

package adder_share_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int DEFAULT_W     = 4;
  localparam int DEFAULT_N_REQ = 4;

  // A single requester still needs a one-bit id field, so clamp at 1.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
//
// Purpose : picks the first asserted request at or after ptr+1 (mod N) and
//           returns it one-hot and encoded. Purely combinational.
// Ports   : req        in  N     request vector
//           ptr        in  ID_W  index of the most recent winner
//           enable     in  1     gates the one-hot grant (index is still computed)
//           grant      out N     one-hot grant, zero when disabled or no request
//           grant_idx  out ID_W  encoded winner, 0 when no request
//           any_req    out 1     at least one request is asserted

module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int N    = DEFAULT_N_REQ,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_req
);

  int cand;

  // Walk the requests in priority order: ptr+1, ptr+2, ... ptr+N (mod N).
  // The last candidate visited is ptr itself, so the previous winner has the
  // lowest priority, which is what makes the rotation fair.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = enable && any_req && (grant_idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one W-bit adder shared round-robin between N_REQ requesters
//
// Purpose : arbitrates N_REQ operand requesters onto a single adder and returns
//           each sum through a one-entry registered response slot tagged with
//           the requester id. Latency 1 cycle, throughput 1 op/cycle.
// Config  : ADDSHARE_SAT_EN - when defined, a carry saturates the W-bit sum to
//           all ones and rsp_data[W] stays 0; otherwise the carry lands in
//           rsp_data[W].
// Ports   : clk        in  1        clock, rising edge
//           reset      in  1        asynchronous, active-high reset
//           req_valid  in  N_REQ    per-requester operand valid
//           req_a      in  N_REQ*W  operand A, requester i at [i*W +: W]
//           req_b      in  N_REQ*W  operand B, same packing
//           req_ready  out N_REQ    per-requester accept, one-hot or zero
//           rsp_valid  out 1        response slot holds a result
//           rsp_data   out W+1      sum {carry, sum[W-1:0]}
//           rsp_id     out ID_W     requester that produced rsp_data
//           rsp_ready  in  1        consumer accepts the response

module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter  int W     = DEFAULT_W,
  parameter  int N_REQ = DEFAULT_N_REQ,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [W:0]         rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  input  logic               rsp_ready
);

  slot_state_e     state_q;
  slot_state_e     state_d;
  logic            can_accept;
  logic            grant_en;
  logic            fire;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            any_req;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W:0]      sum_raw;
  logic [W:0]      result;

  // The slot can take a new result when it is empty, or when the current one
  // leaves this very cycle. This is a deliberate combinational path from
  // rsp_ready to req_ready so a full slot still sustains one op per cycle.
  // req_ready is forced low while reset is held.
  always_comb begin
    can_accept = (state_q == EMPTY) || rsp_ready;
    grant_en   = can_accept && !reset;
  end

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (grant_en),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // A grant is only ever issued to a valid requester, so any grant bit is a transfer.
  assign fire = |req_ready;

  // Operand mux driven by the encoded winner.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  // The one shared adder. Zero-extension means the W+1 bit result never wraps.
  assign sum_raw = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADDSHARE_SAT_EN
  assign result = sum_raw[W] ? {1'b0, {W{1'b1}}} : sum_raw;
`else
  assign result = sum_raw;
`endif

  // Slot FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (fire) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // A grant while FULL implies rsp_ready, so FULL stays FULL back-to-back.
        if (rsp_ready && !fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign rsp_valid = (state_q == FULL);

  // The reset value of rr_ptr points at the last requester so that
  // requester 0 is searched first after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      rr_ptr   <= ID_W'(N_REQ - 1);
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state_q <= state_d;
      // Priority rotates only on an actual transfer; idle and stalled cycles
      // leave rr_ptr and the held response untouched.
      if (fire) begin
        rsp_data <= result;
        rsp_id   <= grant_idx;
        rr_ptr   <= grant_idx;
      end
    end
  end

  // any_req is folded into the one-hot grant inside the arbiter; it is kept
  // visible here for debug probing only.
  logic unused_any_req;
  assign unused_any_req = any_req;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter

module tb_adder_share_arbiter;

  localparam int W = 4;
  localparam int N = 4;

`ifdef ADDSHARE_SAT_EN
  localparam logic [4:0] OVF_SUM = 5'h0F;
  localparam bit         SAT     = 1'b1;
`else
  localparam logic [4:0] OVF_SUM = 5'h10;
  localparam bit         SAT     = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W:0]     rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state: one response slot and the last winner.
  int m_full;
  int m_data;
  int m_id;
  int m_ptr;

  adder_share_arbiter #(.W(W), .N_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_full = 0;
    m_data = 0;
    m_id   = 0;
    m_ptr  = N - 1;
  endfunction

  // Winner is the first valid requester after the previous winner, circularly.
  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int model_sum(input int a, input int b);
    int s;
    s = a + b;
    if (SAT && s >= (1 << W)) s = (1 << W) - 1;
    return s;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply_reset(input bit check_state);
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    if (check_state) begin
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_data",  32'(rsp_data),  32'd0);
      chk("reset_rsp_id",    32'(rsp_id),    32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One model-checked cycle. Starts and ends at a falling edge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                      input logic rr, output logic [N-1:0] seen_ready);
    int w;
    logic [N-1:0] er;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #2;
    w  = model_winner(v);
    er = '0;
    if ((m_full == 0 || rr) && w >= 0) er[w] = 1'b1;
    seen_ready = req_ready;
    chk("m_req_ready", 32'(req_ready), 32'(er));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full != 0) begin
      chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
      chk("m_rsp_id",   32'(rsp_id),   32'(m_id));
    end
    @(posedge clk);
    if (er != 0) begin
      m_data = model_sum(int'(a[w*W +: W]), int'(b[w*W +: W]));
      m_id   = w;
      m_ptr  = w;
      m_full = 1;
    end else if (rr) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] v;
    logic [15:0]  a;
    logic [15:0]  b;
    bit           rr;
    logic [N-1:0] e_ready;
    bit           e_valid;
    logic [4:0]   e_data;
    logic [1:0]   e_id;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [N-1:0] seen;

    // Single transfer, round-robin order, hold, overflow.
    tbl[0]  = '{1'b1, 4'b0001, 16'h0003, 16'h0004, 1'b1, 4'b0001, 1'b0, 5'h00, 2'd0};
    tbl[1]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 5'h07, 2'd0};
    tbl[2]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 5'h00, 2'd0};
    tbl[3]  = '{1'b1, 4'b1111, 16'h3210, 16'h1111, 1'b1, 4'b0001, 1'b0, 5'h00, 2'd0};
    tbl[4]  = '{1'b0, 4'b1111, 16'h3210, 16'h1111, 1'b1, 4'b0010, 1'b1, 5'h01, 2'd0};
    tbl[5]  = '{1'b0, 4'b1111, 16'h3210, 16'h1111, 1'b1, 4'b0100, 1'b1, 5'h02, 2'd1};
    tbl[6]  = '{1'b0, 4'b1111, 16'h3210, 16'h1111, 1'b1, 4'b1000, 1'b1, 5'h03, 2'd2};
    tbl[7]  = '{1'b0, 4'b1111, 16'h3210, 16'h1111, 1'b1, 4'b0001, 1'b1, 5'h04, 2'd3};
    tbl[8]  = '{1'b0, 4'b1111, 16'h3210, 16'h1111, 1'b1, 4'b0010, 1'b1, 5'h01, 2'd0};
    tbl[9]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 5'h02, 2'd1};
    tbl[10] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 5'h02, 2'd1};
    tbl[11] = '{1'b0, 4'b0010, 16'h00F0, 16'h0010, 1'b1, 4'b0010, 1'b1, 5'h02, 2'd1};
    tbl[12] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b1, OVF_SUM, 2'd1};
    tbl[13] = '{1'b0, 4'b0001, 16'h000F, 16'h0001, 1'b1, 4'b0001, 1'b0, 5'h00, 2'd0};
    tbl[14] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, OVF_SUM, 2'd0};

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset(1'b1);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) apply_reset(1'b0);
      req_valid = tbl[i].v;
      req_a     = tbl[i].a;
      req_b     = tbl[i].b;
      rsp_ready = tbl[i].rr;
      #2;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_data", i), 32'(rsp_data), 32'(tbl[i].e_data));
        chk($sformatf("tbl%0d_id", i),   32'(rsp_id),   32'(tbl[i].e_id));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Backpressure: FULL and stalled for three cycles, then same-cycle release.
    apply_reset(1'b0);
    step(4'b0001, 16'h0003, 16'h0004, 1'b1, seen);
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 16'h0560, 16'h0120, 1'b0, seen);
      chk("bp_stall_ready", 32'(seen), 32'd0);
    end
    step(4'b0110, 16'h0560, 16'h0120, 1'b1, seen);
    chk("bp_release_grant", 32'(seen), 32'b0010);
    step(4'b0000, 16'h0000, 16'h0000, 1'b0, seen);

    // Asynchronous reset while FULL with every requester valid.
    step(4'b1111, 16'h1234, 16'h4321, 1'b1, seen);
    req_valid = 4'b1111;
    reset     = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(4'b1111, 16'h1234, 16'h4321, 1'b1, seen);
    chk("post_rst_first_grant", 32'(seen), 32'b0001);

    // Idle cycles must not disturb the pointer.
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) step(4'b0100, 16'h0500, 16'h0200, 1'b1, seen);
    for (int i = 0; i < 3; i++) step(4'b0000, 16'h0000, 16'h0000, 1'b1, seen);
    step(4'b1100, 16'h9500, 16'h1200, 1'b1, seen);
    chk("idle_req3_next", 32'(seen), 32'b1000);
    step(4'b1100, 16'h9500, 16'h1200, 1'b1, seen);
    chk("idle_req2_after", 32'(seen), 32'b0100);

    // Random traffic against the model.
    apply_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0), seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
